// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-counter / fetch unit.
package pc_fetch_unit_pkg;

  typedef enum logic [2:0] {
    PcStop   = 3'd0,
    PcIncr   = 3'd1,
    PcJAL    = 3'd2,
    PcJALR   = 3'd3,
    PcBranch = 3'd4,
    PcTrap   = 3'd5,
    PcMret   = 3'd6,
    PcRsvd   = 3'd7
  } pc_op_e;

  typedef enum logic [1:0] {
    PcReset = 2'd0,
    PcFetch = 2'd1,
    PcHalt  = 2'd2
  } pc_state_e;

  // Instruction addresses must be word aligned.
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;
  localparam int unsigned PC_STEP       = 4;

  // True when the low address bits violate word alignment.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & PC_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_ras.sv
// Circular return-address stack: push/pop/replace-top, overwrite-oldest when full.
module pc_ras
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic            valid,
  output logic [XLEN-1:0] top
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  top_q;
  logic             valid_q;

  // Entry storage: push+pop rewrites the top slot, plain push writes the next slot.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      mem_q[ptr_q] <= push_data;
    end else if (push) begin
      mem_q[ptr_q + PTR_W'(1)] <= push_data;
    end
  end

  // Pointer, occupancy and registered top-of-stack view.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      top_q   <= '0;
      valid_q <= 1'b0;
    end else if (push && pop) begin
      cnt_q   <= (cnt_q == '0) ? CNT_W'(1) : cnt_q;
      top_q   <= push_data;
      valid_q <= 1'b1;
    end else if (push) begin
      ptr_q   <= ptr_q + PTR_W'(1);
      cnt_q   <= (cnt_q == CNT_W'(RAS_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
      top_q   <= push_data;
      valid_q <= 1'b1;
    end else if (pop && (cnt_q != '0)) begin
      ptr_q   <= ptr_q - PTR_W'(1);
      cnt_q   <= cnt_q - CNT_W'(1);
      top_q   <= mem_q[ptr_q - PTR_W'(1)];
      valid_q <= (cnt_q != CNT_W'(1));
    end
  end

  assign valid = valid_q;
  assign top   = top_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with fetch handshake, deferred redirect and misalignment trap.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_imm_data,
  input  logic [XLEN-1:0] i_alu_res_data,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic [XLEN-1:0] i_epc,
  input  logic            i_link,
  input  logic            i_ret,
  input  logic            i_if_ready,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_addr,
  output logic [XLEN-1:0] o_imm_data,
  output logic [XLEN-1:0] o_ret_data,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_misalign_addr,
  output logic            o_ras_valid,
  output logic [XLEN-1:0] o_ras_top
);

  pc_state_e       state_q, state_d;
  logic            valid_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pending_q, pending_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  pc_op_e          op;
  logic            fire;
  logic            accept;
  logic            redirect;
  logic            check_align;
  logic            halt_op;
  logic            bad_op;
  logic            misaligned;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] dest;

  assign op     = pc_op_e'(i_op);
  assign fire   = valid_q & i_if_ready;
  // A redirect is taken directly when the current address is consumed or none is offered.
  assign accept = (state_q != PcReset) & (fire | ~valid_q);

  // State register and PC datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= PcReset;
      valid_q    <= 1'b0;
      pc_q       <= RESET_VEC;
      pend_q     <= '0;
      pending_q  <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= (state_d == PcFetch);
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pending_q  <= pending_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  // Op decode, next-state and next-PC selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pending_d   = pending_q;
    mis_d       = 1'b0;
    mis_addr_d  = mis_addr_q;
    redirect    = 1'b0;
    check_align = 1'b0;
    halt_op     = 1'b0;
    bad_op      = 1'b0;
    target      = '0;

    case (op)
      PcStop, PcRsvd: halt_op = 1'b1;
      PcIncr: ;
      PcJAL: begin
        redirect    = 1'b1;
        check_align = 1'b1;
        target      = pc_q + i_imm_data;
      end
      PcJALR: begin
        redirect    = 1'b1;
        check_align = 1'b1;
        target      = i_alu_res_data & ~XLEN'(1);
      end
      PcBranch: begin
        if (i_br_taken) begin
          redirect    = 1'b1;
          check_align = 1'b1;
          target      = pc_q + i_imm_data;
        end
      end
      PcTrap: begin
        redirect = 1'b1;
        target   = i_trap_vec;
      end
      PcMret: begin
        redirect = 1'b1;
        target   = i_epc;
      end
      default: bad_op = 1'b1;
    endcase

    misaligned = check_align & is_misaligned(target[1:0]);
    dest       = misaligned ? i_trap_vec : target;

    case (state_q)
      PcReset: state_d = PcFetch;
      PcFetch, PcHalt: begin
        if (!bad_op) begin
          state_d = halt_op ? PcHalt : PcFetch;
          if (redirect) begin
            if (accept) begin
              pc_d      = dest;
              pending_d = 1'b0;
            end else begin
              pend_d    = dest;
              pending_d = 1'b1;
            end
          end else if (fire && pending_q) begin
            pc_d      = pend_q;
            pending_d = 1'b0;
          end else if (fire && !halt_op) begin
            pc_d = pc_q + XLEN'(PC_STEP);
          end
          mis_d = misaligned;
          if (misaligned) begin
            mis_addr_d = target;
          end
        end
      end
      default: state_d = PcReset;
    endcase
  end

  // Simulation diagnostics for reserved and unknown op encodings.
  always_ff @(posedge clk) begin
    if (rstn && (state_q != PcReset)) begin
      if ($isunknown(i_op)) begin
        $error("pc_fetch_unit: undefined op encoding, pc held");
      end else if (op == PcRsvd) begin
        $warning("pc_fetch_unit: PcRsvd treated as PcStop");
      end
    end
  end

  assign o_if_valid      = valid_q;
  assign o_if_addr       = pc_q;
  assign o_imm_data      = pc_q + i_imm_data;
  assign o_ret_data      = pc_q + XLEN'(PC_STEP);
  assign o_misalign      = mis_q;
  assign o_misalign_addr = mis_addr_q;

`ifdef PC_RAS_EN
  logic ras_push;
  logic ras_pop;

  // Link/return hints act when the control transfer itself is accepted.
  assign ras_push = accept & i_link & ((op == PcJAL) | (op == PcJALR));
  assign ras_pop  = accept & i_ret & (op == PcJALR);

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rstn      (rstn),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (o_ret_data),
    .valid     (o_ras_valid),
    .top       (o_ras_top)
  );
`else
  logic unused_ras_hints;

  assign unused_ras_hints = ^{i_link, i_ret, RAS_DEPTH[0]};
  assign o_ras_valid      = 1'b0;
  assign o_ras_top        = '0;
`endif

endmodule
